// File: rtl/pipe_stage_buf.sv
// Reusable inter-stage pipeline register with a 2-entry skid buffer and a valid/ready handshake.
// It also provides flush, zero-control bubbles, occupancy reporting and a saturating stall counter.
module pipe_stage_buf #(
   parameter int unsigned CTRL_W = 5,
   parameter int unsigned DATA_W = 107,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   input  logic              clr_cnt,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e              state_q, state_d;
   logic                out_valid_q, out_valid_d;
   logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

   logic                in_ready_c;
   logic                in_fire;
   logic                out_fire;

   // Upstream ready depends only on held state, never on out_ready.
   assign in_ready_c = ~reset & (state_q != TWO);
   assign in_fire    = in_valid & in_ready_c;
   assign out_fire   = out_valid_q & out_ready;

   // State and storage registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= EMPTY;
         out_valid_q <= 1'b0;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Next-state, storage steering and stall counting.
   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      stall_cnt_d = stall_cnt_q;

      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
                  state_d     = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (in_fire) begin
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
                  state_d     = TWO;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
                  state_d     = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end

      out_valid_d = (state_d != EMPTY);

      if (clr_cnt) begin
         stall_cnt_d = '0;
      end else if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   assign in_ready  = in_ready_c;
   assign out_valid = out_valid_q;
   // Bubbles always present zero control so no write side effects leak downstream.
   assign out_ctrl  = out_valid_q ? main_ctrl_q : '0;
   assign out_data  = main_data_q;
   assign occupancy = state_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: the driver queues accepted words, and a negedge
// monitor pops and compares them whenever the block hands a word downstream.
module tb_pipe_stage_buf;

   localparam int unsigned CTRL_W = 5;
   localparam int unsigned DATA_W = 107;
   localparam int unsigned CNT_W  = 4;

   typedef struct packed {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } word_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic              flush = 1'b0;
   logic              clr_cnt = 1'b0;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;

   int    errors = 0;
   int    checks = 0;
   word_t exp_q[$];

   pipe_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .flush(flush), .clr_cnt(clr_cnt), .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [CTRL_W-1:0] mkc(input int k);
      return CTRL_W'(k * 3 + 1);
   endfunction

   function automatic logic [DATA_W-1:0] mkd(input int k);
      return DATA_W'({32'(k) ^ 32'hA5A5_0000, 32'(k * 7 + 1), 32'(k)});
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle of stimulus, starting 1 time unit after a rising edge.
   task automatic cyc(input logic v, input int k, input logic ordy, input logic fl,
                      input logic clr, input int eocc, input int erdy);
      word_t w;
      in_valid  = v;
      in_ctrl   = mkc(k);
      in_data   = mkd(k);
      out_ready = ordy;
      flush     = fl;
      clr_cnt   = clr;
      #2;
      if (eocc >= 0) begin
         chk("occupancy", 128'(occupancy), 128'(eocc));
         chk("out_valid", 128'(out_valid), 128'(eocc != 0));
      end
      if (erdy >= 0) chk("in_ready", 128'(in_ready), 128'(erdy));
      if (v && in_ready && !fl && !reset) begin
         w.c = mkc(k);
         w.d = mkd(k);
         exp_q.push_back(w);
      end
      @(posedge clk);
      #1;
      if (fl) exp_q.delete();
   endtask

   // Monitor: every downstream handshake must match the oldest queued word.
   always @(negedge clk) begin
      word_t w;
      if (!out_valid) chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", 128'(out_data), 128'(0));
            if (out_data == '0) begin
               errors++;
               $display("FAIL unexpected_word: got word with zero data expected none");
            end
         end else begin
            w = exp_q.pop_front();
            chk("out_ctrl", 128'(out_ctrl), 128'(w.c));
            chk("out_data", 128'(out_data), 128'(w.d));
         end
      end
   end

   initial begin
      // Reset held for three edges with a live upstream word.
      in_valid = 1'b1;
      in_ctrl  = 5'h1F;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_occ", 128'(occupancy), 128'(0));
         chk("rst_valid", 128'(out_valid), 128'(0));
         chk("rst_ctrl", 128'(out_ctrl), 128'(0));
         chk("rst_ready", 128'(in_ready), 128'(0));
         chk("rst_stall", 128'(stall_cnt), 128'(0));
      end
      reset = 1'b0;

      // Single word A.
      cyc(1, 1, 1, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0, 0, 1);

      // Streaming at full rate.
      cyc(1, 2, 1, 0, 0, 0, 1);
      cyc(1, 3, 1, 0, 0, 1, 1);
      cyc(1, 4, 1, 0, 0, 1, 1);
      cyc(1, 5, 1, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0, 0, 1);
      chk("stream_stall", 128'(stall_cnt), 128'(0));

      // Back-pressure: 7 lands in skid, 8 held upstream.
      cyc(1, 6, 1, 0, 0, 0, 1);
      cyc(1, 7, 0, 0, 0, 1, 1);
      cyc(1, 8, 0, 0, 0, 2, 0);
      cyc(1, 8, 0, 0, 0, 2, 0);
      cyc(1, 8, 1, 0, 0, 2, 0);
      cyc(1, 8, 1, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0, 0, 1);
      chk("bp_stall", 128'(stall_cnt), 128'(3));

      // Flush while full; 12 offered but never accepted.
      cyc(1, 9, 1, 0, 0, 0, 1);
      cyc(1, 10, 0, 0, 0, 1, 1);
      cyc(1, 11, 0, 0, 0, 2, 0);
      cyc(1, 12, 0, 1, 0, 2, 0);
      chk("flush_ctrl", 128'(out_ctrl), 128'(0));
      cyc(1, 13, 1, 0, 0, 0, 1);
      // Flush with both handshakes: 13 consumed, 14 discarded.
      cyc(1, 14, 1, 1, 0, 1, 1);
      cyc(0, 0, 1, 0, 0, 0, 1);
      cyc(1, 15, 1, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0, 0, 1);
      chk("flush_stall", 128'(stall_cnt), 128'(6));

      // Stall counter saturation, clear and resume.
      cyc(1, 16, 0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 1, 1);
      chk("stall_sat", 128'(stall_cnt), 128'(15));
      cyc(0, 0, 0, 0, 1, 1, 1);
      chk("stall_clr", 128'(stall_cnt), 128'(0));
      cyc(0, 0, 0, 0, 0, 1, 1);
      chk("stall_resume", 128'(stall_cnt), 128'(1));
      cyc(0, 0, 1, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0, 0, 1);
      chk("stall_hold", 128'(stall_cnt), 128'(1));

      // Asynchronous reset pulse between edges while full.
      cyc(1, 17, 0, 0, 0, 0, 1);
      cyc(1, 18, 0, 0, 0, 1, 1);
      cyc(1, 19, 0, 0, 0, 2, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_occ", 128'(occupancy), 128'(0));
      chk("arst_valid", 128'(out_valid), 128'(0));
      chk("arst_ready", 128'(in_ready), 128'(0));
      chk("arst_ctrl", 128'(out_ctrl), 128'(0));
      chk("arst_stall", 128'(stall_cnt), 128'(0));
      exp_q.delete();
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      cyc(0, 0, 1, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 0, 1);
      cyc(1, 20, 1, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0, 0, 1);

      chk("drain_empty", 128'(exp_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register that replaces the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries a control bundle and a data bundle between two pipeline stages under a valid/ready handshake. A 2-entry skid buffer gives full throughput with no combinational path from downstream ready to upstream ready. It adds synchronous flush, bubble insertion (control cleared when empty), occupancy reporting and a saturating stall counter.

## Interface
- CTRL_W, 5 — control bundle width (e.g. MemRd, MemWr, RegWr, MemToReg[1:0]); zeroed on bubbles.
- DATA_W, 107 — data bundle width (e.g. ALUOut, WriteData, pc_plus_4, AddrC, Opcode).
- CNT_W, 16 — stall counter width.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has a word.
- in_ready  out  1  block can accept a word.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data bundle; value is don't-care when out_valid=0.
- flush  in  1  synchronous kill of all held words.
- clr_cnt  in  1  synchronous clear of stall_cnt.
- occupancy  out  2  words held: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

## Operation
- Storage consists of a main register, which drives out_*, and a skid register, each with a valid bit.
- State is encoded by occupancy: EMPTY(0), ONE(1), TWO(2).
- Input handshake fires when in_valid and in_ready are both 1. Output handshake fires when out_valid and out_ready are both 1.
- in_ready = ~reset & (occupancy != 2). It depends only on state, never on out_ready.
- out_valid = (occupancy != 0).
- State transitions, when flush=0:
  - EMPTY: input handshake → load main, go to ONE. Otherwise stay in EMPTY.
  - ONE, input and output handshakes together → load main with new word, stay in ONE.
  - ONE, input handshake only → load skid, go to TWO.
  - ONE, output handshake only → go to EMPTY.
  - ONE, neither handshake → hold.
  - TWO: output handshake → main<=skid, go to ONE. Otherwise hold. No input is accepted because in_ready=0.
- Ordering is strict FIFO; no word is ever dropped or duplicated except by flush.
- flush=1 has top priority:
  - Next state is EMPTY.
  - Any input handshake in that cycle is discarded.
  - An output handshake in that cycle still counts as consumed by downstream.
- out_ctrl = main_ctrl gated by out_valid, so every bubble presents zero control (no MemWr/RegWr).
- stall_cnt:
  - Increments by 1 on each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W−1.
  - clr_cnt=1 sets it to 0 and has priority over increment.
  - flush does not affect it.

## Timing
- Reset (asynchronous, active-high) forces, immediately and while held:
  - occupancy=0, out_valid=0, in_ready=0, out_ctrl=0, stall_cnt=0.
  - Main and skid data registers = 0.
- First acceptance is possible on the first rising edge after reset deasserts.
- Reset asserted mid-operation discards all held words, with no partial update.
- Latency: a word accepted at edge N is presented on out_* right after edge N when the block was EMPTY, or ONE with a simultaneous output handshake.
- Throughput is 1 word/cycle with out_ready held at 1.
- After out_ready falls, at most 1 further word is accepted (into skid). in_ready falls in the cycle after that acceptance.
- flush at edge N: out_valid=0 and occupancy=0 right after edge N; in_ready=1 (if reset=0).
- All outputs are registered except:
  - in_ready: state plus reset.
  - out_ctrl: gating by valid.

## Test plan
- Reset held 3 cycles with in_valid=1, in_ctrl=5'h1F → out_valid=0, out_ctrl=0, in_ready=0, stall_cnt=0. After release, word A appears on out one edge after acceptance.
- Streaming, out_ready=1: send A,B,C,D on consecutive cycles → out shows A,B,C,D on consecutive cycles, occupancy stays 1, in_ready stays 1, stall_cnt=0.
- Back-pressure: stream A,B,C, drop out_ready after A is presented → B lands in skid, occupancy=2, in_ready=0, C held upstream. Raise out_ready → A,B,C delivered in order. stall_cnt equals the number of low out_ready cycles with out_valid=1.
- Flush at occupancy=2 with simultaneous input word X → occupancy=0, out_valid=0, out_ctrl=0 next cycle, X never appears. The next word Y passes normally.
- Stall counter with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt saturates at 15. clr_cnt=1 for one cycle → 0. Counter resumes at 1 on the next stalled cycle.
- Asynchronous reset pulse mid-stream (between edges) at occupancy=2 → outputs zero immediately, no held word is delivered after release.
